// File: rtl/uart_pkg.sv
// Shared UART framing definitions used by both transmitter and receiver
// so the two ends agree on baud timing and frame layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int BITDUR_DEFAULT = 1736;  // 200 MHz / 115200 baud
    localparam int DATA_BITS      = 8;
    localparam int STOP_BITS      = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BITDUR-1 while enabled, flags the last cycle
// of each bit and wraps to zero there.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int BITDUR = BITDUR_DEFAULT,
    localparam int W     = $clog2(BITDUR)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [W-1:0] count;

    assign tc = (count == W'(BITDUR - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, with a one-byte holding
// register so consecutive frames go out with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BITDUR = BITDUR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 out,
    output logic                 busy
);

    localparam int IW = $clog2(DATA_BITS);

    uart_state_t          state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 hold_full, hold_full_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 out_n;
    logic                 tc;

    // Timer is held at zero in IDLE so every frame starts on a fresh count.
    uart_bit_timer #(.BITDUR(BITDUR)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .tc     (tc)
    );

    assign ready = ~hold_full;
    assign busy  = (state != IDLE) | hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            idx       <= '0;
            out       <= 1'b1;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            idx       <= idx_n;
            out       <= out_n;
        end
    end

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        hold_full_n = hold_full;
        idx_n       = idx;
        out_n       = out;

        // Accept and transfer are mutually exclusive since ready = ~hold_full.
        if (valid && !hold_full) begin
            hold_n      = data;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                out_n = 1'b1;
                if (hold_full) begin
                    shift_n     = hold;
                    hold_full_n = 1'b0;
                    out_n       = 1'b0;
                    state_n     = START;
                end
            end
            START: begin
                if (tc) begin
                    idx_n   = '0;
                    out_n   = shift[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tc) begin
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_n   = '0;
                        out_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                        out_n = shift[idx_n];
                    end
                end
            end
            STOP: begin
                if (tc) begin
                    if (hold_full) begin
                        shift_n     = hold;
                        hold_full_n = 1'b0;
                        out_n       = 1'b0;
                        state_n     = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: predicts the line, ready and busy each cycle
// from the accept times and frame arithmetic.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int B     = 16;
    localparam int FRAME = 10 * B;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       busy;

    uart_tx #(.BITDUR(B)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input int e, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %b expected %b", tag, e, got, exp);
    endtask

    // Reference model: accept edge, frame start edge and byte of each accepted item.
    int         acc_t[$];
    int         start_t[$];
    logic [7:0] bytes[$];
    int         last_start;

    function automatic void model_clear();
        acc_t.delete();
        start_t.delete();
        bytes.delete();
        last_start = -1000000;
    endfunction

    function automatic void record(input int a, input logic [7:0] b);
        int s;
        s = (a + 1 > last_start + FRAME) ? a + 1 : last_start + FRAME;
        acc_t.push_back(a);
        start_t.push_back(s);
        bytes.push_back(b);
        last_start = s;
    endfunction

    function automatic logic exp_out(input int e);
        int k;
        for (int i = start_t.size() - 1; i >= 0; i--) begin
            if (e >= start_t[i] && e < start_t[i] + FRAME) begin
                k = (e - start_t[i]) / B;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return bytes[i][k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_ready(input int e);
        for (int i = 0; i < acc_t.size(); i++)
            if (acc_t[i] <= e && e < start_t[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int e);
        for (int i = 0; i < acc_t.size(); i++)
            if (acc_t[i] <= e && e < start_t[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    int         e = 0;
    bit         pending = 1'b0;
    logic [7:0] cur;

    task automatic check_all();
        check("out", e, out, exp_out(e));
        check("ready", e, ready, exp_ready(e));
        check("busy", e, busy, exp_busy(e));
    endtask

    // One clock: check outputs, then drive the handshake for the next edge.
    task automatic step(input int rate);
        @(posedge clk);
        #1;
        e++;
        check_all();
        if (!pending && $urandom_range(99) < rate) begin
            pending = 1'b1;
            cur     = 8'($urandom);
        end
        valid = pending;
        data  = pending ? cur : 8'($urandom);
        if (pending && exp_ready(e)) begin
            record(e + 1, cur);
            pending = 1'b0;
        end
    endtask

    // valid is held high through reset to show it is ignored.
    task automatic do_reset();
        reset   = 1'b1;
        valid   = 1'b1;
        data    = 8'($urandom);
        pending = 1'b0;
        @(posedge clk);
        #1;
        e++;
        model_clear();
        reset = 1'b0;
        valid = 1'b0;
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        model_clear();

        // Single 0x55 frame from idle.
        do_reset();
        pending = 1'b1;
        cur     = 8'h55;
        for (int i = 0; i < 200; i++) step(0);

        // Back-to-back 0xA5, 0x3C.
        pending = 1'b1;
        cur     = 8'hA5;
        step(0);
        pending = 1'b1;
        cur     = 8'h3C;
        for (int i = 0; i < 2 * FRAME + 20; i++) step(0);

        // Mixed traffic, then saturated valid (backpressure), then sparse.
        for (int i = 0; i < 3000; i++) step(30);
        for (int i = 0; i < 2000; i++) step(100);
        for (int i = 0; i < 1500; i++) step(5);

        // Reset in the middle of data bit 3 of 0xF0 with another byte held.
        do_reset();
        pending = 1'b1;
        cur     = 8'hF0;
        for (int i = 0; i < 200; i++) begin
            if (start_t.size() == 1 && !pending && acc_t.size() == 1) begin
                pending = 1'b1;
                cur     = 8'h77;
            end
            if (start_t.size() > 0 && e == start_t[0] + 4 * B + B / 2) break;
            step(0);
        end
        check("held_before_reset", e, ready, 1'b0);
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(0);

        // Random traffic with occasional resets.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 400 + $urandom_range(300); i++) step(60);
            do_reset();
        end
        for (int i = 0; i < FRAME + 20; i++) step(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
